// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, mux selects, IR layout, opcodes.
// Build option: MC_R0_ZERO_EN (hard-wired zero r0) is consumed by mc_regfile.
package mc_pkg;

    typedef enum logic [3:0] {
        ALU_PASSA = 4'b0000,
        ALU_NOTA  = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0011,
        ALU_OR    = 4'b0100,
        ALU_AND   = 4'b0101,
        ALU_XOR   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_PASSB = 4'b1000
    } alu_sel_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'b00,
        WB_MDR    = 2'b01,
        WB_LI     = 2'b10,
        WB_LUI    = 2'b11
    } memtoreg_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10,
        PCS_HOLD   = 2'b11
    } pcsource_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_SEXT = 2'b10,
        SRCB_ZEXT = 2'b11
    } alusrcb_e;

    localparam int IR_OPC_HI  = 31;
    localparam int IR_OPC_LO  = 26;
    localparam int IR_RD_HI   = 25;
    localparam int IR_RD_LO   = 21;
    localparam int IR_RS_HI   = 20;
    localparam int IR_RS_LO   = 16;
    localparam int IR_RT_HI   = 15;
    localparam int IR_RT_LO   = 11;
    localparam int IR_IMM_HI  = 15;
    localparam int IR_JADDR_HI = 25;

    localparam logic [5:0] OP_NOP       = 6'b000000;
    localparam logic [5:0] OP_J         = 6'b000001;
    localparam logic [5:0] OP_BEQ       = 6'b100000;
    localparam logic [3:0] OP_RTYPE_PFX = 4'b0100;
    localparam logic [1:0] OP_ITYPE_PFX = 2'b11;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Control/memory bundle between controller, memories and the datapath.
// slave = datapath side, master = controller/memory side.
interface mc_datapath_if;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IRWrite;
    logic        RegWrite;
    logic        RegReadSel;
    logic        ALUSrcA;
    logic        DMEMWrite;
    logic [1:0]  MemtoReg;
    logic [1:0]  PCSource;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUSel;
    logic [5:0]  opcode;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;

    modport slave (
        input  PCWrite, PCWriteCond, IRWrite, RegWrite, RegReadSel, ALUSrcA, DMEMWrite,
        input  MemtoReg, PCSource, ALUSrcB, ALUSel, imem_rdata, dmem_rdata,
        output opcode, imem_addr, dmem_addr, dmem_wdata, dmem_we
    );

    modport master (
        output PCWrite, PCWriteCond, IRWrite, RegWrite, RegReadSel, ALUSrcA, DMEMWrite,
        output MemtoReg, PCSource, ALUSrcB, ALUSel, imem_rdata, dmem_rdata,
        input  opcode, imem_addr, dmem_addr, dmem_wdata, dmem_we
    );
endinterface

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one posedge write port, async clear.
// MC_R0_ZERO_EN defined: r0 reads 0 and ignores writes; undefined: r0 is ordinary.
module mc_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_regs [32];
    logic        w_we;

`ifdef MC_R0_ZERO_EN
    assign w_we     = i_we && (i_waddr != 5'd0);
    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];
`else
    assign w_we     = i_we;
    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];
`endif

    // Reads see the pre-edge contents, so a same-cycle read of the written register is old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: PC, IR, regfile, A/B/ALUOut/MDR and ALU, one micro-step per clock.
// Optional MC_R0_ZERO_EN selects a hard-wired zero r0 inside mc_regfile.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    mc_datapath_if.slave   bus
);

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_mdr;

    logic [4:0]  w_rd;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [15:0] w_imm;
    logic [25:0] w_jaddr;
    logic [4:0]  w_raddr2;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;
    logic        w_zero;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc_next;
    logic        w_pc_en;

    assign w_rd     = r_ir[IR_RD_HI:IR_RD_LO];
    assign w_rs     = r_ir[IR_RS_HI:IR_RS_LO];
    assign w_rt     = r_ir[IR_RT_HI:IR_RT_LO];
    assign w_imm    = r_ir[IR_IMM_HI:0];
    assign w_jaddr  = r_ir[IR_JADDR_HI:0];
    // BEQ and SWI compare/store the register named by rd, so port 2 can be steered to it.
    assign w_raddr2 = bus.RegReadSel ? w_rd : w_rt;

    mc_regfile u_regfile (
        .clk      (clk),
        .rst_n    (reset),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_raddr2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (bus.RegWrite),
        .i_waddr  (w_rd),
        .i_wdata  (w_wb_data)
    );

    assign w_alu_a = bus.ALUSrcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        case (alusrcb_e'(bus.ALUSrcB))
            SRCB_B:    w_alu_b = r_b;
            SRCB_FOUR: w_alu_b = 32'd4;
            SRCB_SEXT: w_alu_b = sext16(w_imm);
            SRCB_ZEXT: w_alu_b = {16'd0, w_imm};
            default:   w_alu_b = r_b;
        endcase
    end

    always_comb begin
        w_alu_y = 32'd0;
        case (alu_sel_e'(bus.ALUSel))
            ALU_PASSA: w_alu_y = w_alu_a;
            ALU_NOTA:  w_alu_y = ~w_alu_a;
            ALU_ADD:   w_alu_y = w_alu_a + w_alu_b;
            ALU_SUB:   w_alu_y = w_alu_a - w_alu_b;
            ALU_OR:    w_alu_y = w_alu_a | w_alu_b;
            ALU_AND:   w_alu_y = w_alu_a & w_alu_b;
            ALU_XOR:   w_alu_y = w_alu_a ^ w_alu_b;
            ALU_SLT:   w_alu_y = ($signed(w_alu_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
            ALU_PASSB: w_alu_y = w_alu_b;
            default:   w_alu_y = 32'd0;
        endcase
    end

    assign w_zero = (w_alu_y == 32'd0);

    always_comb begin
        w_wb_data = r_aluout;
        case (memtoreg_e'(bus.MemtoReg))
            WB_ALUOUT: w_wb_data = r_aluout;
            WB_MDR:    w_wb_data = r_mdr;
            WB_LI:     w_wb_data = {16'd0, w_imm};
            WB_LUI:    w_wb_data = {w_imm, 16'd0};
            default:   w_wb_data = r_aluout;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        case (pcsource_e'(bus.PCSource))
            PCS_ALU:    w_pc_next = w_alu_y;
            PCS_ALUOUT: w_pc_next = r_aluout;
            PCS_JUMP:   w_pc_next = {r_pc[31:28], w_jaddr, 2'b00};
            PCS_HOLD:   w_pc_next = r_pc;
            default:    w_pc_next = r_pc;
        endcase
    end

    assign w_pc_en = bus.PCWrite | (bus.PCWriteCond & w_zero);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
            r_mdr    <= 32'd0;
        end else begin
            if (bus.IRWrite) begin
                r_ir <= bus.imem_rdata;
            end
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            r_a      <= w_rdata1;
            r_b      <= w_rdata2;
            r_aluout <= w_alu_y;
            r_mdr    <= bus.dmem_rdata;
        end
    end

    assign bus.opcode     = r_ir[IR_OPC_HI:IR_OPC_LO];
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_addr  = r_aluout;
    assign bus.dmem_wdata = r_b;
    assign bus.dmem_we    = bus.DMEMWrite;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed + randomized bench for mc_datapath; register contents are observed through B -> dmem_wdata.
module tb_mc_datapath;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [31:0] model_rf [32];
    logic [31:0] rv;

    mc_datapath_if bus();

    mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegReadSel  = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.DMEMWrite   = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.PCSource    = 2'b11;
        bus.ALUSrcB     = 2'b00;
        bus.ALUSel      = 4'b0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] w);
        idle();
        bus.imem_rdata = w;
        bus.IRWrite    = 1'b1;
        step();
        idle();
    endtask

    // Builds any 32-bit value in register r: LUI the high half, then ORI the low half.
    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        load_ir({6'b110000, r, r, v[31:16]});
        bus.MemtoReg = 2'b11;
        bus.RegWrite = 1'b1;
        step();
        load_ir({6'b110000, r, r, v[15:0]});
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b11;
        bus.ALUSel  = 4'b0100;
        step();
        idle();
        bus.MemtoReg = 2'b00;
        bus.RegWrite = 1'b1;
        step();
        idle();
        model_rf[r] = v;
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        load_ir({6'b010000, 5'd0, 5'd0, r, 11'd0});
        step();
        v = bus.dmem_wdata;
    endtask

    function automatic logic [31:0] alu_ref(input int sel, input logic [31:0] a, input logic [31:0] b);
        if (sel == 0) return a;
        if (sel == 1) return ~a;
        if (sel == 2) return a + b;
        if (sel == 3) return a - b;
        if (sel == 4) return a | b;
        if (sel == 5) return a & b;
        if (sel == 6) return a ^ b;
        if (sel == 7) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (sel == 8) return b;
        return 32'd0;
    endfunction

    task automatic set_pc_jump(input logic [25:0] ja);
        load_ir({6'b000001, ja});
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        step();
        idle();
    endtask

    task automatic run_beq();
        load_ir({6'b100000, 5'd2, 5'd1, 16'h0020});
        bus.RegReadSel = 1'b1;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b10;
        bus.ALUSel     = 4'b0010;
        step();
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = 2'b00;
        bus.ALUSel      = 4'b0011;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        step();
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        idle();
        bus.imem_rdata = 32'd0;
        bus.dmem_rdata = 32'd0;
        reset = 1'b0;
        step();
        step();
        chk("rst_pc", bus.imem_addr, 32'h0);
        chk("rst_opcode", {26'd0, bus.opcode}, 32'h0);
        chk("rst_dmem_we", {31'd0, bus.dmem_we}, 32'h0);
        chk("rst_dmem_addr", bus.dmem_addr, 32'h0);
        chk("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
        reset = 1'b1;

        // fetch: IR and PC update together
        bus.imem_rdata = 32'hC862_FFFF;
        bus.IRWrite  = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b01;
        bus.ALUSel   = 4'b0010;
        bus.PCSource = 2'b00;
        step();
        idle();
        chk("fetch_opcode", {26'd0, bus.opcode}, 32'h0000_0032);
        chk("fetch_pc", bus.imem_addr, 32'h4);

        // ADDI and ORI
        set_reg(5'd2, 32'd5);
        load_ir({6'b110000, 5'd3, 5'd2, 16'hFFFF});
        step();
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ALUSel = 4'b0010;
        step();
        idle(); bus.RegWrite = 1'b1;
        step();
        idle();
        read_reg(5'd3, rv);
        chk("addi_r3", rv, 32'd4);
        load_ir({6'b110000, 5'd3, 5'd2, 16'hFFFF});
        step();
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b11; bus.ALUSel = 4'b0100;
        step();
        idle(); bus.RegWrite = 1'b1;
        step();
        idle();
        read_reg(5'd3, rv);
        chk("ori_r3", rv, 32'h0000_FFFF);

        // BEQ taken / not taken
        set_reg(5'd1, 32'd7);
        set_reg(5'd2, 32'd7);
        set_pc_jump(26'h4);
        chk("jmp_pc10", bus.imem_addr, 32'h10);
        run_beq();
        chk("beq_taken", bus.imem_addr, 32'h30);
        set_reg(5'd2, 32'd8);
        set_pc_jump(26'h4);
        run_beq();
        chk("beq_not_taken", bus.imem_addr, 32'h10);

        // LI / LUI
        load_ir({6'b110000, 5'd5, 5'd0, 16'h8001});
        bus.MemtoReg = 2'b10; bus.RegWrite = 1'b1;
        step();
        load_ir({6'b110000, 5'd6, 5'd0, 16'h8001});
        bus.MemtoReg = 2'b11; bus.RegWrite = 1'b1;
        step();
        idle();
        read_reg(5'd5, rv);
        chk("li_r5", rv, 32'h0000_8001);
        read_reg(5'd6, rv);
        chk("lui_r6", rv, 32'h8001_0000);

        // J keeps PC[31:28]
        set_reg(5'd7, 32'h1000_0004);
        load_ir({6'b110000, 5'd0, 5'd7, 16'h0});
        step();
        bus.PCWrite = 1'b1; bus.ALUSrcA = 1'b1; bus.ALUSel = 4'b0000; bus.PCSource = 2'b00;
        step();
        idle();
        chk("pc_from_alu", bus.imem_addr, 32'h1000_0004);
        set_pc_jump(26'h000_0040);
        chk("jump_pc", bus.imem_addr, 32'h1000_0100);

        // SWI / LWI
        set_reg(5'd1, 32'h0000_0100);
        set_reg(5'd4, 32'hDEAD_BEEF);
        load_ir({6'b111000, 5'd4, 5'd1, 16'h0008});
        bus.RegReadSel = 1'b1;
        step();
        bus.RegReadSel = 1'b1; bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ALUSel = 4'b0010;
        step();
        idle();
        bus.RegReadSel = 1'b1;
        bus.DMEMWrite  = 1'b1;
        #1;
        chk("swi_addr", bus.dmem_addr, 32'h0000_0108);
        chk("swi_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
        chk("swi_we", {31'd0, bus.dmem_we}, 32'h1);
        step();
        idle();
        bus.dmem_rdata = 32'h1234_5678;
        load_ir({6'b111001, 5'd8, 5'd1, 16'h0008});
        bus.MemtoReg = 2'b01; bus.RegWrite = 1'b1;
        step();
        idle();
        read_reg(5'd8, rv);
        chk("lwi_r8", rv, 32'h1234_5678);
        model_rf[8] = 32'h1234_5678;

        // randomized R-type operations against the behavioural model
        for (int n = 0; n < 24; n++) begin
            logic [4:0]  rs, rt, rd;
            int          sel;
            logic [31:0] exp;
            rs  = 5'($urandom_range(1, 31));
            rt  = 5'($urandom_range(1, 31));
            rd  = 5'($urandom_range(1, 31));
            sel = $urandom_range(0, 15);
            set_reg(rs, $urandom);
            if ((n % 4) == 0) set_reg(rt, model_rf[rs]);
            else set_reg(rt, $urandom);
            exp = alu_ref(sel, model_rf[rs], model_rf[rt]);
            load_ir({6'b010000, rd, rs, rt, 11'd0});
            step();
            bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b00; bus.ALUSel = 4'(sel);
            step();
            idle(); bus.RegWrite = 1'b1;
            step();
            idle();
            model_rf[rd] = exp;
            read_reg(rd, rv);
            chk($sformatf("rand%0d_op%0d_r%0d", n, sel, rd), rv, model_rf[rd]);
        end

        // asynchronous reset in the middle of an execute step
        load_ir({6'b110000, 5'd3, 5'd4, 16'h0001});
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ALUSel = 4'b0010;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_pc", bus.imem_addr, 32'h0);
        chk("midrst_opcode", {26'd0, bus.opcode}, 32'h0);
        chk("midrst_dmem_addr", bus.dmem_addr, 32'h0);
        chk("midrst_dmem_wdata", bus.dmem_wdata, 32'h0);
        idle();
        step();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        read_reg(5'd4, rv);
        chk("midrst_r4", rv, 32'h0);
        read_reg(5'd6, rv);
        chk("midrst_r6", rv, 32'h0);

        // r0 behaviour depends on the build option
        load_ir({6'b110000, 5'd0, 5'd0, 16'h0005});
        bus.MemtoReg = 2'b10; bus.RegWrite = 1'b1;
        step();
        idle();
        read_reg(5'd0, rv);
`ifdef MC_R0_ZERO_EN
        chk("r0_write", rv, 32'd0);
`else
        chk("r0_write", rv, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
